// File: rtl/wb_seq_pkg.sv
// Shared definitions for the Wishbone sequential master: FSM state encoding,
// default parameter values, counter widths and the user address region base.
package wb_seq_pkg;

   // Command sequencer states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAITW = 3'd1,
      ST_REQ   = 3'd2,
      ST_HOLDR = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam int          DEF_TIMEOUT  = 255;
   localparam int          DEF_ADR_STEP = 4;
   localparam int          CNT_W        = 9;   // holds 1..256 words
   localparam int          WDOG_W       = 16;  // holds TIMEOUT up to 65535
   localparam logic [31:0] USER_BASE    = 32'h3800_0000;

   // Word count of a command: a length field of zero stands for 256 words
   function automatic logic [CNT_W-1:0] words_of(input logic [7:0] len);
      return (len == 8'd0) ? CNT_W'(256) : {1'b0, len};
   endfunction

endpackage

// File: rtl/wb_seq_watchdog.sv
// Strobe watchdog: counts consecutive cycles with run=1 and no clear, and
// flags expiry on the TIMEOUT-th such cycle so the strobe lasts exactly
// TIMEOUT cycles. An ack (clear) in the same cycle takes precedence.
module wb_seq_watchdog
   import wb_seq_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic clear,
   output logic expired
);

   logic [WDOG_W-1:0] cnt_q, cnt_d;

   // Next count: advance while the strobe waits, restart otherwise
   always_comb begin
      cnt_d = '0;
      if (run && !clear) begin
         cnt_d = cnt_q + WDOG_W'(1);
      end
   end

   // Cycle counter register with synchronous active-low reset
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = run && !clear && (cnt_q == WDOG_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_seq_master.sv
// Wishbone classic initiator that turns one command (direction, start address,
// byte lanes, word count) into a burst of single-word cycles with CYC held for
// the whole command. Optional feature: define WB_SEQ_MASTER_TIMEOUT_EN to add
// a strobe watchdog that aborts a stuck command and raises the sticky err_o.
module wb_seq_master
   import wb_seq_pkg::*;
#(
   parameter int TIMEOUT  = DEF_TIMEOUT,
   parameter int ADR_STEP = DEF_ADR_STEP
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_we_i,
   input  logic [31:0] cmd_adr_i,
   input  logic [3:0]  cmd_sel_i,
   input  logic [7:0]  cmd_len_i,
   input  logic        wdat_valid_i,
   input  logic [31:0] wdat_i,
   output logic        wdat_ready_o,
   output logic        rdat_valid_o,
   output logic [31:0] rdat_o,
   input  logic        rdat_ready_i,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   output logic        done_o,
   output logic        err_o
);

   if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("wb_seq_master: TIMEOUT must be within 1..65535");
   end

   state_e            state_q, state_d;
   logic              we_q, we_d;
   logic [3:0]        sel_q, sel_d;
   logic [31:0]       adr_q, adr_d;
   logic [31:0]       dat_q, dat_d;
   logic [31:0]       rdat_q, rdat_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              timeout_w;

`ifdef WB_SEQ_MASTER_TIMEOUT_EN
   logic              err_q, err_d;

   wb_seq_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (wb_clk_i),
      .rst_n   (wb_rst_n_i),
      .run     (wbm_stb_o),
      .clear   (wbm_ack_i),
      .expired (timeout_w)
   );

   assign err_o = err_q;
`else
   assign timeout_w = 1'b0;
   assign err_o     = 1'b0;
`endif

   // Next-state, datapath updates and state-decoded handshake outputs
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d      = state_q;
      we_d         = we_q;
      sel_d        = sel_q;
      adr_d        = adr_q;
      dat_d        = dat_q;
      rdat_d       = rdat_q;
      cnt_d        = cnt_q;
`ifdef WB_SEQ_MASTER_TIMEOUT_EN
      err_d        = err_q;
`endif
      cmd_ready_o  = 1'b0;
      wdat_ready_o = 1'b0;
      rdat_valid_o = 1'b0;
      wbm_cyc_o    = 1'b0;
      wbm_stb_o    = 1'b0;
      done_o       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) begin
               we_d    = cmd_we_i;
               sel_d   = cmd_sel_i;
               adr_d   = cmd_adr_i;
               cnt_d   = words_of(cmd_len_i);
`ifdef WB_SEQ_MASTER_TIMEOUT_EN
               err_d   = 1'b0;
`endif
               state_d = cmd_we_i ? ST_WAITW : ST_REQ;
            end
         end
         ST_WAITW: begin
            wbm_cyc_o    = 1'b1;
            wdat_ready_o = 1'b1;
            if (wdat_valid_i) begin
               dat_d   = wdat_i;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            wbm_cyc_o = 1'b1;
            wbm_stb_o = 1'b1;
            if (wbm_ack_i) begin
               adr_d = adr_q + 32'(ADR_STEP);
               cnt_d = cnt_q - CNT_W'(1);
               if (!we_q) begin
                  rdat_d  = wbm_dat_i;
                  state_d = ST_HOLDR;
               end else begin
                  state_d = (cnt_q > CNT_W'(1)) ? ST_WAITW : ST_DONE;
               end
            end else if (timeout_w) begin
               // Abandon the remaining words of the command
               cnt_d   = '0;
`ifdef WB_SEQ_MASTER_TIMEOUT_EN
               err_d   = 1'b1;
`endif
               state_d = ST_DONE;
            end
         end
         ST_HOLDR: begin
            wbm_cyc_o    = 1'b1;
            rdat_valid_o = 1'b1;
            if (rdat_ready_i) begin
               state_d = (cnt_q != '0) ? ST_REQ : ST_DONE;
            end
         end
         ST_DONE: begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers, synchronous active-low reset
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         sel_q   <= '0;
         adr_q   <= '0;
         dat_q   <= '0;
         rdat_q  <= '0;
         cnt_q   <= '0;
`ifdef WB_SEQ_MASTER_TIMEOUT_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         rdat_q  <= rdat_d;
         cnt_q   <= cnt_d;
`ifdef WB_SEQ_MASTER_TIMEOUT_EN
         err_q   <= err_d;
`endif
      end
   end

   assign wbm_we_o  = we_q;
   assign wbm_sel_o = sel_q;
   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = dat_q;
   assign rdat_o    = rdat_q;

endmodule

// File: tb/tb_wb_seq_master.sv
// Self-checking bench for wb_seq_master: reset values, read/write bursts from
// a vector table, hand-written latency, spurious-ack, reset-abort and (when
// WB_SEQ_MASTER_TIMEOUT_EN is defined) timeout sequences, then random commands
// checked against a word-level reference model with its own memory image.
module tb_wb_seq_master;
   import wb_seq_pkg::*;

   localparam int TO   = 20;
   localparam int STEP = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0, cmd_we = 1'b0;
   logic [31:0] cmd_adr = '0;
   logic [3:0]  cmd_sel = '0;
   logic [7:0]  cmd_len = '0;
   logic        cmd_ready;
   logic        wdat_valid = 1'b0;
   logic [31:0] wdat = '0;
   logic        wdat_ready;
   logic        rdat_valid, rdat_ready = 1'b0;
   logic [31:0] rdat;
   logic        cyc, stb, we, done, err;
   logic [3:0]  sel;
   logic [31:0] adr, dat_o;
   logic [31:0] dat_i = '0;
   logic        ack, ack_r = 1'b0, spur_ack = 1'b0;

   assign ack = ack_r | spur_ack;

   wb_seq_master #(.TIMEOUT(TO), .ADR_STEP(STEP)) dut (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
      .cmd_adr_i(cmd_adr), .cmd_sel_i(cmd_sel), .cmd_len_i(cmd_len),
      .wdat_valid_i(wdat_valid), .wdat_i(wdat), .wdat_ready_o(wdat_ready),
      .rdat_valid_o(rdat_valid), .rdat_o(rdat), .rdat_ready_i(rdat_ready),
      .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
      .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack),
      .done_o(done), .err_o(err)
   );

   always #5 clk = ~clk;

   // ---------------- responder with its own memory ----------------
   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
   } txn_t;

   txn_t        txn_q[$];
   logic [31:0] mem[logic [31:0]];
   int          ack_delay = 0;
   bit          never_ack = 1'b0;
   int          wcnt = 0;

   // Unwritten locations: the user base reads DEADBEEF, others a fixed pattern
   function automatic logic [31:0] dflt(input logic [31:0] a);
      return (a == USER_BASE) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_5A5A);
   endfunction

   always @(posedge clk) begin
      txn_t t;
      #1;
      if (ack_r) begin
         ack_r = 1'b0;
      end else if (stb && !never_ack) begin
         if (wcnt >= ack_delay) begin
            wcnt = 0;
            if (we) mem[adr] = dat_o;
            else    dat_i = mem.exists(adr) ? mem[adr] : dflt(adr);
            t.we = we; t.adr = adr; t.sel = sel; t.dat = we ? dat_o : dat_i;
            txn_q.push_back(t);
            ack_r = 1'b1;
         end else begin
            wcnt++;
         end
      end else begin
         wcnt = 0;
      end
   end

   // ---------------- bus event monitor ----------------
   int   done_cnt = 0, cyc_rises = 0, stb_rises = 0, stb_run = 0, last_run = 0;
   logic cyc_prev = 1'b0, stb_prev = 1'b0;

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (cyc && !cyc_prev) cyc_rises++;
      if (stb && !stb_prev) stb_rises++;
      if (stb) stb_run++;
      else begin
         if (stb_run != 0) last_run = stb_run;
         stb_run = 0;
      end
      cyc_prev = cyc;
      stb_prev = stb;
   end

   // ---------------- checking helpers ----------------
   int tests = 0, fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic issue_cmd(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [7:0] l);
      int g = 0;
      while (!cmd_ready && g < 200) begin step(); g++; end
      check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
      cmd_we = w; cmd_adr = a; cmd_sel = s; cmd_len = l; cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] d, input int gap);
      int g = 0;
      repeat (gap) step();
      wdat = d; wdat_valid = 1'b1;
      while (!wdat_ready && g < 200) begin step(); g++; end
      check("wdat_ready_wait", {31'd0, wdat_ready}, 32'd1);
      step();
      wdat_valid = 1'b0;
   endtask

   task automatic recv_word(input int stall, output logic [31:0] d);
      int g = 0;
      while (!rdat_valid && g < 200) begin step(); g++; end
      check("rdat_valid_wait", {31'd0, rdat_valid}, 32'd1);
      for (int s = 0; s < stall; s++) begin
         step();
         check("stall_stb_low", {31'd0, stb}, 32'd0);
         check("stall_valid_held", {31'd0, rdat_valid}, 32'd1);
      end
      d = rdat;
      rdat_ready = 1'b1;
      step();
      rdat_ready = 1'b0;
   endtask

   task automatic wait_done();
      int g = 0;
      while (!done && g < 2000) begin step(); g++; end
      check("done_seen", {31'd0, done}, 32'd1);
   endtask

   // ---------------- reference model and command runner ----------------
   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [3:0]  sel;
      logic [7:0]  len;
      int          stall;
      int          dly;
      logic [31:0] dbase;
      logic        chk_first;
      logic [31:0] exp_first;
   } vec_t;

   logic [31:0] ref_mem[logic [31:0]];
   logic [31:0] wdata_q[$];

   task automatic run_vec(input vec_t v, input int gap_max);
      int          n, t0, d0, c0, s0;
      logic [31:0] got[$];
      logic [31:0] exp_rd[$];
      logic [31:0] a, e, d;
      n  = (v.len == 8'd0) ? 256 : int'(v.len);
      t0 = txn_q.size(); d0 = done_cnt; c0 = cyc_rises; s0 = stb_rises;
      ack_delay = v.dly;
      issue_cmd(v.we, v.adr, v.sel, v.len);
      for (int i = 0; i < n; i++) begin
         if (v.we) send_word(wdata_q[i], (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max)));
         else begin recv_word(v.stall, d); got.push_back(d); end
      end
      wait_done();
      step();
      check("txn_count", 32'(txn_q.size() - t0), 32'(n));
      for (int i = 0; i < n; i++) begin
         a = v.adr + 32'(i * STEP);
         e = v.we ? wdata_q[i] : (ref_mem.exists(a) ? ref_mem[a] : dflt(a));
         if (v.we) ref_mem[a] = e;
         else      exp_rd.push_back(e);
         if (t0 + i < txn_q.size()) begin
            check("bus_adr", txn_q[t0 + i].adr, a);
            check("bus_we",  {31'd0, txn_q[t0 + i].we}, {31'd0, v.we});
            check("bus_sel", {28'd0, txn_q[t0 + i].sel}, {28'd0, v.sel});
            check("bus_dat", txn_q[t0 + i].dat, e);
         end
      end
      for (int i = 0; i < exp_rd.size(); i++) check("rd_data", got[i], exp_rd[i]);
      if (v.chk_first && txn_q.size() > t0)
         check("first_word", v.we ? txn_q[t0].dat : got[0], v.exp_first);
      check("done_pulses", 32'(done_cnt - d0), 32'd1);
      check("cyc_phases",  32'(cyc_rises - c0), 32'd1);
      check("stb_phases",  32'(stb_rises - s0), 32'(n));
      check("err_clear",   {31'd0, err}, 32'd0);
   endtask

   // ---------------- test sequence ----------------
   vec_t tbl[9];

   initial begin
      vec_t        v;
      int          n, t0, d0, g;
      logic [31:0] hold;

      tbl[0] = '{1'b0, 32'h3800_0000, 4'hF, 8'd1, 0, 11, 32'h0,         1'b1, 32'hDEAD_BEEF};
      tbl[1] = '{1'b1, 32'h3800_0010, 4'hF, 8'd4, 0, 0,  32'h1,         1'b1, 32'h0000_0001};
      tbl[2] = '{1'b0, 32'h3800_0010, 4'hF, 8'd4, 0, 1,  32'h0,         1'b1, 32'h0000_0001};
      tbl[3] = '{1'b0, 32'h3800_0010, 4'hF, 8'd3, 5, 2,  32'h0,         1'b1, 32'h0000_0001};
      tbl[4] = '{1'b1, 32'h3800_0100, 4'h3, 8'd2, 0, 3,  32'hCAFE_0000, 1'b1, 32'hCAFE_0000};
      tbl[5] = '{1'b0, 32'h3800_0100, 4'h3, 8'd2, 0, 0,  32'h0,         1'b1, 32'hCAFE_0000};
      tbl[6] = '{1'b1, 32'hFFFF_FFFC, 4'hF, 8'd0, 0, 0,  32'h1000_0000, 1'b1, 32'h1000_0000};
      tbl[7] = '{1'b0, 32'h0000_0000, 4'hF, 8'd2, 0, 0,  32'h0,         1'b1, 32'h1000_0001};
      tbl[8] = '{1'b0, 32'h3800_0200, 4'hC, 8'd3, 1, 1,  32'h0,         1'b1, 32'h9DA5_585A};

      // Reset values
      repeat (3) step();
      check("rst_cyc", {31'd0, cyc}, 32'd0);
      check("rst_stb", {31'd0, stb}, 32'd0);
      check("rst_we", {31'd0, we}, 32'd0);
      check("rst_sel", {28'd0, sel}, 32'd0);
      check("rst_adr", adr, 32'd0);
      check("rst_dat", dat_o, 32'd0);
      check("rst_rdat", rdat, 32'd0);
      check("rst_flags", {28'd0, done, err, rdat_valid, wdat_ready}, 32'd0);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      rst_n = 1'b1;
      step();

      // Read latency, spurious acks outside REQ, single-cycle done
      ack_delay = 0;
      cmd_we = 1'b0; cmd_adr = 32'h3800_0040; cmd_sel = 4'h5; cmd_len = 8'd1; cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      check("lat_stb_after_accept", {31'd0, stb}, 32'd1);
      check("lat_adr", adr, 32'h3800_0040);
      check("lat_sel", {28'd0, sel}, 32'h5);
      step();
      check("lat_rvalid_next", {31'd0, rdat_valid}, 32'd1);
      check("lat_stb_dropped", {31'd0, stb}, 32'd0);
      check("lat_rdat", rdat, dflt(32'h3800_0040));
      hold = rdat;
      spur_ack = 1'b1;
      step();
      spur_ack = 1'b0;
      check("spur_holdr_valid", {31'd0, rdat_valid}, 32'd1);
      check("spur_holdr_rdat", rdat, hold);
      check("spur_holdr_stb", {31'd0, stb}, 32'd0);
      rdat_ready = 1'b1;
      step();
      rdat_ready = 1'b0;
      check("done_pulse", {31'd0, done}, 32'd1);
      check("done_cyc_low", {31'd0, cyc}, 32'd0);
      step();
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("idle_ready", {31'd0, cmd_ready}, 32'd1);
      spur_ack = 1'b1;
      step();
      spur_ack = 1'b0;
      check("spur_idle_cyc", {31'd0, cyc}, 32'd0);
      check("spur_idle_ready", {31'd0, cmd_ready}, 32'd1);

      // Reset during the third word of an 8-word read
      ack_delay = 2;
      rdat_ready = 1'b1;
      t0 = txn_q.size(); d0 = done_cnt;
      issue_cmd(1'b0, 32'h3800_0300, 4'hF, 8'd8);
      g = 0;
      while (!((txn_q.size() - t0) == 2 && stb) && g < 200) begin step(); g++; end
      check("third_word_reached", {31'd0, stb}, 32'd1);
      rst_n = 1'b0;
      step();
      check("rst_mid_cyc", {31'd0, cyc}, 32'd0);
      check("rst_mid_stb", {31'd0, stb}, 32'd0);
      check("rst_mid_rvalid", {31'd0, rdat_valid}, 32'd0);
      rst_n = 1'b1;
      repeat (4) step();
      rdat_ready = 1'b0;
      check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
      check("rst_mid_idle", {31'd0, cmd_ready}, 32'd1);

      // Vector table
      foreach (tbl[r]) begin
         wdata_q.delete();
         n = (tbl[r].len == 8'd0) ? 256 : int'(tbl[r].len);
         if (tbl[r].we) for (int i = 0; i < n; i++) wdata_q.push_back(tbl[r].dbase + 32'(i));
         run_vec(tbl[r], 0);
      end

`ifdef WB_SEQ_MASTER_TIMEOUT_EN
      // Responder never acks: abort after TO strobe cycles
      never_ack = 1'b1;
      t0 = txn_q.size(); d0 = done_cnt;
      issue_cmd(1'b0, 32'h3800_0400, 4'hF, 8'd3);
      wait_done();
      check("to_stb_cycles", 32'(last_run), 32'(TO));
      check("to_err_set", {31'd0, err}, 32'd1);
      check("to_cyc_low", {31'd0, cyc}, 32'd0);
      step();
      check("to_done_once", 32'(done_cnt - d0), 32'd1);
      check("to_err_sticky", {31'd0, err}, 32'd1);
      check("to_no_txn", 32'(txn_q.size() - t0), 32'd0);
      never_ack = 1'b0;
      v = '{1'b0, 32'h3800_0010, 4'hF, 8'd1, 0, 0, 32'h0, 1'b1, 32'h0000_0001};
      run_vec(v, 0);
`endif

      // Random commands against the reference model
      for (int k = 0; k < 25; k++) begin
         v.we        = 1'($urandom_range(0, 1));
         v.adr       = USER_BASE + 32'($urandom_range(0, 63) * 4);
         v.sel       = 4'($urandom);
         v.len       = 8'($urandom_range(1, 6));
         v.stall     = int'($urandom_range(0, 3));
         v.dly       = int'($urandom_range(0, 3));
         v.dbase     = '0;
         v.chk_first = 1'b0;
         v.exp_first = '0;
         wdata_q.delete();
         for (int i = 0; i < int'(v.len); i++) wdata_q.push_back($urandom);
         run_vec(v, 2);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
